// File: rtl/simd_alu_pipelined_acc_pkg.sv
// Shared types for the pipelined SIMD ALU: lane modes, ALUMODE encodings,
// the decoded operation and the control bundle that travels down the pipe.
package simd_alu_pkg;

  localparam logic [1:0] SIMD_ONE  = 2'b00;
  localparam logic [1:0] SIMD_TWO  = 2'b01;
  localparam logic [1:0] SIMD_FOUR = 2'b10;
  localparam logic [1:0] SIMD_RSVD = 2'b11;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_LOGIC = 4'b1100;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_XOR,
    OP_AND,
    OP_OR
  } alu_op_e;

  typedef struct packed {
    logic [3:0] alumode;
    logic       opmode3;
    logic [1:0] use_simd;
    logic       acc_en;
    logic       acc_clr;
    logic       cin;
  } ctrl_t;

  // Illegal encodings fall back to add; alumode_legal() flags them.
  function automatic alu_op_e decode_op(input logic [3:0] alumode, input logic opmode3);
    casez (alumode)
      4'b0011: return OP_SUB;
      4'b01??: return OP_XOR;
      4'b11??: return opmode3 ? OP_OR : OP_AND;
      default: return OP_ADD;
    endcase
  endfunction

  function automatic logic alumode_legal(input logic [3:0] alumode);
    casez (alumode)
      4'b0000, 4'b0011, 4'b01??, 4'b11??: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/simd_alu_pipelined_acc_if.sv
// Operand/control/result bundle of the pipelined SIMD ALU.
interface simd_alu_pipelined_acc_if #(
  parameter int WIDTH = 48
);
  logic             in_valid;
  logic [3:0]       ALUMODE;
  logic             OPMODE3;
  logic [1:0]       USE_SIMD;
  logic             acc_en;
  logic             acc_clr;
  logic [WIDTH-1:0] W;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Z;
  logic             CIN;
  logic             out_valid;
  logic [WIDTH-1:0] P;
  logic [7:0]       carry_out;
  logic [3:0]       ovf_sticky;
  logic             cfg_err;

  modport master (
    output in_valid, ALUMODE, OPMODE3, USE_SIMD, acc_en, acc_clr, W, X, Y, Z, CIN,
    input  out_valid, P, carry_out, ovf_sticky, cfg_err
  );

  modport slave (
    input  in_valid, ALUMODE, OPMODE3, USE_SIMD, acc_en, acc_clr, W, X, Y, Z, CIN,
    output out_valid, P, carry_out, ovf_sticky, cfg_err
  );
endinterface

// File: rtl/simd_alu_slice.sv
// One LW-bit slice: 4-operand add chain (2-bit carry), a second chain that
// forms zf + ~sum + 1 for subtract, and the bitwise ops.
module simd_alu_slice
  import simd_alu_pkg::*;
#(
  parameter int LW = 12
) (
  input  alu_op_e         op,
  input  logic [LW-1:0]   w,
  input  logic [LW-1:0]   x,
  input  logic [LW-1:0]   y,
  input  logic [LW-1:0]   zf,
  input  logic [1:0]      ca_in,
  input  logic            cb_in,
  output logic [LW-1:0]   res,
  output logic [1:0]      ca_out,
  output logic            cb_out,
  output logic [1:0]      carry
);

  logic [LW+1:0] sum_a;
  logic [LW:0]   sum_b;

  // NOTE: every output of this always_comb is given a value before any branch,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sum_a = {2'b00, w} + {2'b00, x} + {2'b00, y} + {{LW{1'b0}}, ca_in};
    if (op != OP_SUB) sum_a = sum_a + {2'b00, zf};
    sum_b = {1'b0, zf} + {1'b0, ~sum_a[LW-1:0]} + {{LW{1'b0}}, cb_in};
    res   = sum_a[LW-1:0];
    carry = sum_a[LW+1:LW];
    case (op)
      OP_SUB: begin
        res   = sum_b[LW-1:0];
        carry = {1'b0, sum_b[LW]};
      end
      OP_XOR:  res = x ^ zf;
      OP_AND:  res = x & zf;
      OP_OR:   res = x | zf;
      default: ;
    endcase
  end

  assign ca_out = sum_a[LW+1:LW];
  assign cb_out = sum_b[LW];

endmodule

// File: rtl/simd_alu_pipelined_acc.sv
// Two-stage SIMD ALU: S1 registers operands and controls, S2 computes over
// four slices with lane-dependent carry breaks, P feedback and sticky overflow.
module simd_alu_pipelined_acc
  import simd_alu_pkg::*;
#(
  parameter int WIDTH = 48
) (
  input logic                     clk,
  input logic                     reset,
  simd_alu_pipelined_acc_if.slave bus
);

  localparam int LW = WIDTH / 4;

  logic             s1_valid;
  ctrl_t            ctrl_s1;
  logic [WIDTH-1:0] w_s1, x_s1, y_s1, z_s1;

  // NOTE: state is written with <= so every register samples pre-edge values,
  // independent of the order the always_ff blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      ctrl_s1  <= '0;
      w_s1     <= '0;
      x_s1     <= '0;
      y_s1     <= '0;
      z_s1     <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        ctrl_s1 <= '{alumode: bus.ALUMODE, opmode3: bus.OPMODE3, use_simd: bus.USE_SIMD,
                     acc_en: bus.acc_en, acc_clr: bus.acc_clr, cin: bus.CIN};
        w_s1    <= bus.W;
        x_s1    <= bus.X;
        y_s1    <= bus.Y;
        z_s1    <= bus.Z;
      end
    end
  end

  alu_op_e          op;
  logic [1:0]       mode;
  logic             err;
  logic [2:0]       bnd;       // bnd[i]: lane boundary above slice i
  logic [3:0]       lane_top;
  logic [WIDTH-1:0] zf;
  logic [WIDTH-1:0] res;
  logic [3:0][1:0]  carry;
  logic [3:0]       ovf_raw;

  always_comb begin
    op       = decode_op(ctrl_s1.alumode, ctrl_s1.opmode3);
    mode     = (ctrl_s1.use_simd == SIMD_RSVD) ? SIMD_ONE : ctrl_s1.use_simd;
    err      = (ctrl_s1.use_simd == SIMD_RSVD) || !alumode_legal(ctrl_s1.alumode);
    bnd      = {mode == SIMD_FOUR, (mode == SIMD_FOUR) || (mode == SIMD_TWO), mode == SIMD_FOUR};
    lane_top = {1'b1, bnd};
    zf       = ctrl_s1.acc_clr ? '0 : (ctrl_s1.acc_en ? bus.P : z_s1);
  end

  for (genvar i = 0; i < 4; i++) begin : g_slice
    logic [1:0] ca_in, ca_out;
    logic       cb_in, cb_out;

    if (i == 0) begin : g_lsb
      assign ca_in = {1'b0, ctrl_s1.cin};
      assign cb_in = 1'b1;
    end else begin : g_upper
      assign ca_in = bnd[i-1] ? 2'b00 : g_slice[i-1].ca_out;
      assign cb_in = bnd[i-1] | g_slice[i-1].cb_out;
    end

    if (i == 3) begin : g_msb
      logic unused_chain;
      assign unused_chain = ^{ca_out, cb_out};
    end

    simd_alu_slice #(.LW(LW)) u_slice (
      .op     (op),
      .w      (w_s1[i*LW +: LW]),
      .x      (x_s1[i*LW +: LW]),
      .y      (y_s1[i*LW +: LW]),
      .zf     (zf[i*LW +: LW]),
      .ca_in  (ca_in),
      .cb_in  (cb_in),
      .res    (res[i*LW +: LW]),
      .ca_out (ca_out),
      .cb_out (cb_out),
      .carry  (carry[i])
    );
  end

  // A borrow-free subtract leaves exactly 01 in the lane-top carry pair.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ovf_raw[k] = 1'b0;
      if (lane_top[k]) begin
        if (op == OP_ADD)      ovf_raw[k] = (carry[k] != 2'b00);
        else if (op == OP_SUB) ovf_raw[k] = (carry[k] != 2'b01);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid  <= 1'b0;
      bus.P          <= '0;
      bus.carry_out  <= '0;
      bus.ovf_sticky <= '0;
      bus.cfg_err    <= 1'b0;
    end else begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.P          <= res;
        bus.carry_out  <= carry;
        bus.ovf_sticky <= (ctrl_s1.acc_clr ? 4'b0000 : bus.ovf_sticky) | ovf_raw;
        bus.cfg_err    <= err;
      end
    end
  end

endmodule

// File: tb/tb_simd_alu_pipelined_acc.sv
// Directed bench for simd_alu_pipelined_acc: inputs change on the falling
// edge, outputs are read on the falling edge after the capturing rising edge.
module tb_simd_alu_pipelined_acc;
  import simd_alu_pkg::*;

  localparam int WIDTH = 48;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simd_alu_pipelined_acc_if #(.WIDTH(WIDTH)) bus ();

  simd_alu_pipelined_acc #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic op(input logic [3:0] alumode, input logic [1:0] simd, input logic opm3,
                    input logic acc_en, input logic acc_clr,
                    input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] x,
                    input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z, input logic cin);
    bus.in_valid = 1'b1;
    bus.ALUMODE  = alumode;
    bus.USE_SIMD = simd;
    bus.OPMODE3  = opm3;
    bus.acc_en   = acc_en;
    bus.acc_clr  = acc_clr;
    bus.W        = w;
    bus.X        = x;
    bus.Y        = y;
    bus.Z        = z;
    bus.CIN      = cin;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    op(ALU_ADD, SIMD_ONE, 0, 0, 0, '0, '0, '0, '0, 0);
    idle();
    repeat (2) tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_p",         64'(bus.P),         64'd0);
    check("rst_carry",     64'(bus.carry_out), 64'd0);
    check("rst_ovf",       64'(bus.ovf_sticky), 64'd0);
    check("rst_cfg_err",   64'(bus.cfg_err),   64'd0);
    rst = 1'b0;
    tick();

    // Single-lane sum with carry-in and 2-cycle latency
    op(ALU_ADD, SIMD_ONE, 0, 0, 0, 48'd1, 48'd2, 48'd3, 48'd4, 1);
    tick(); idle();
    check("t1_valid_c1", 64'(bus.out_valid), 64'd0);
    tick();
    check("t1_valid_c2", 64'(bus.out_valid), 64'd1);
    check("t1_p",        64'(bus.P),         64'd11);
    tick();
    check("t1_valid_drop", 64'(bus.out_valid), 64'd0);
    check("t1_p_hold",     64'(bus.P),         64'd11);

    // Two lanes: carry out of slice 1 must not reach slice 2
    op(ALU_ADD, SIMD_TWO, 0, 0, 0, '0, 48'h0000_00FF_FFFF, '0, 48'd1, 0);
    tick(); idle(); tick();
    check("t2_p",       64'(bus.P),              64'd0);
    check("t2_co_3_2",  64'(bus.carry_out[3:2]), 64'h1);
    check("t2_co_7_4",  64'(bus.carry_out[7:4]), 64'h0);
    check("t2_ovf",     64'(bus.ovf_sticky),     64'b0010);

    // Subtract, back to back: no borrow, then borrow
    op(ALU_SUB, SIMD_ONE, 0, 0, 0, '0, 48'd3, '0, 48'd10, 0);
    tick();
    op(ALU_SUB, SIMD_ONE, 0, 0, 0, '0, 48'd10, '0, 48'd3, 0);
    tick(); idle();
    check("t3a_p",     64'(bus.P),              64'd7);
    check("t3a_co",    64'(bus.carry_out[7:6]), 64'h1);
    check("t3a_ovf3",  64'(bus.ovf_sticky[3]),  64'd0);
    tick();
    check("t3b_p",     64'(bus.P),              64'hFFFF_FFFF_FFF9);
    check("t3b_ovf3",  64'(bus.ovf_sticky[3]),  64'd1);

    // Accumulate X=5 three times; Z is ignored while accumulating
    op(ALU_ADD, SIMD_ONE, 0, 1, 1, '0, 48'd5, '0, 48'h123, 0);
    tick();
    op(ALU_ADD, SIMD_ONE, 0, 1, 0, '0, 48'd5, '0, 48'h123, 0);
    tick();
    op(ALU_ADD, SIMD_ONE, 0, 1, 0, '0, 48'd5, '0, 48'h123, 0);
    check("t4_p1",  64'(bus.P),          64'd5);
    check("t4_ovf", 64'(bus.ovf_sticky), 64'd0);
    tick(); idle();
    check("t4_p2", 64'(bus.P), 64'd10);
    tick();
    check("t4_p3", 64'(bus.P), 64'd15);

    // Four lanes: top lane wraps while accumulating; sticky holds until acc_clr
    op(ALU_ADD, SIMD_FOUR, 0, 1, 1, '0, 48'h0010_0000_0000, '0, '0, 0);
    tick();
    op(ALU_ADD, SIMD_FOUR, 0, 1, 0, '0, 48'hFFF0_0000_0000, '0, '0, 0);
    tick();
    op(ALU_ADD, SIMD_FOUR, 0, 0, 0, '0, 48'd1, '0, 48'd1, 0);
    check("t5_p1",   64'(bus.P),          64'h0010_0000_0000);
    check("t5_ovf1", 64'(bus.ovf_sticky), 64'd0);
    tick();
    op(ALU_ADD, SIMD_FOUR, 0, 0, 1, '0, 48'd7, '0, '0, 0);
    check("t5_p2_top", 64'(bus.P[47:36]),   64'h000);
    check("t5_p2",     64'(bus.P),          64'd0);
    check("t5_ovf2",   64'(bus.ovf_sticky), 64'b1000);
    tick(); idle();
    check("t5_p3",     64'(bus.P),          64'd2);
    check("t5_ovf3",   64'(bus.ovf_sticky), 64'b1000);
    tick();
    check("t5_p4",     64'(bus.P),          64'd7);
    check("t5_ovf4",   64'(bus.ovf_sticky), 64'd0);

    // Logic ops: raw carry still reported, sticky untouched
    op(ALU_XOR, SIMD_ONE, 0, 0, 0, '0, 48'hFFFF_FFFF_FFFF, '0, 48'hFFFF_0000_0000, 0);
    tick();
    op(ALU_LOGIC, SIMD_ONE, 1, 0, 0, '0, 48'hF0F0, '0, 48'hFF00, 0);
    tick();
    op(ALU_LOGIC, SIMD_ONE, 0, 0, 0, '0, 48'hF0F0, '0, 48'hFF00, 0);
    check("t7_xor",    64'(bus.P),              64'h0000_FFFF_FFFF);
    check("t7_xor_co", 64'(bus.carry_out[7:6]), 64'h1);
    check("t7_xor_ovf", 64'(bus.ovf_sticky),    64'd0);
    tick(); idle();
    check("t7_or", 64'(bus.P), 64'hFFF0);
    tick();
    check("t7_and", 64'(bus.P), 64'hF000);

    // Reset with both stages full
    op(ALU_ADD, SIMD_ONE, 0, 0, 0, '0, 48'd9, '0, '0, 0);
    tick();
    op(ALU_ADD, SIMD_ONE, 0, 0, 0, '0, 48'h20, '0, '0, 0);
    tick(); idle();
    check("t6_pre_valid", 64'(bus.out_valid), 64'd1);
    check("t6_pre_p",     64'(bus.P),         64'd9);
    rst = 1'b1;
    #1;
    check("t6_rst_p",     64'(bus.P),         64'd0);
    check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_post_c1", 64'(bus.out_valid), 64'd0);
    tick();
    check("t6_post_c2", 64'(bus.out_valid), 64'd0);

    // Reserved USE_SIMD runs full width; illegal ALUMODE runs as add
    op(ALU_ADD, SIMD_RSVD, 0, 0, 0, '0, 48'h0000_00FF_FFFF, '0, 48'd1, 0);
    tick(); idle(); tick();
    check("t6_rsvd_err",   64'(bus.cfg_err),   64'd1);
    check("t6_rsvd_p",     64'(bus.P),         64'h0000_0100_0000);
    check("t6_rsvd_valid", 64'(bus.out_valid), 64'd1);
    op(4'b0001, SIMD_ONE, 0, 0, 0, 48'd1, 48'd1, '0, '0, 0);
    tick();
    op(ALU_ADD, SIMD_ONE, 0, 0, 0, '0, 48'd3, '0, '0, 0);
    tick(); idle();
    check("t6_bad_mode_err", 64'(bus.cfg_err), 64'd1);
    check("t6_bad_mode_p",   64'(bus.P),       64'd2);
    tick();
    check("t6_legal_err", 64'(bus.cfg_err), 64'd0);
    check("t6_legal_p",   64'(bus.P),       64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
